// File: rtl/cached_fetcher_pkg.sv
// Shared core-pipeline encodings: fetcher and scheduler state codes
// and a saturating counter helper used by the fetcher statistics.
package cached_fetcher_pkg;

   // Fetcher states as seen by the scheduler.
   typedef enum logic [2:0] {
      FETCHER_IDLE     = 3'b000,
      FETCHER_FETCHING = 3'b001,
      FETCHER_FETCHED  = 3'b010
   } fetcher_state_t;

   // Scheduler (core) state codes; other values are don't-care for the fetcher.
   localparam logic [2:0] CORE_IDLE   = 3'b000;
   localparam logic [2:0] CORE_FETCH  = 3'b001;
   localparam logic [2:0] CORE_DECODE = 3'b010;

   localparam int COUNT_BITS = 16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v);
      if (v == {COUNT_BITS{1'b1}}) begin
         return v;
      end
      return v + {{(COUNT_BITS-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/cached_fetcher_if.sv
// Program memory read channel: request (valid/address) out of the fetcher,
// response (ready/data) back from memory.
interface cached_fetcher_if #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 16
);
   logic                 mem_read_valid;
   logic [ADDR_BITS-1:0] mem_read_address;
   logic                 mem_read_ready;
   logic [DATA_BITS-1:0] mem_read_data;

   modport master (
      output mem_read_valid,
      output mem_read_address,
      input  mem_read_ready,
      input  mem_read_data
   );

   modport slave (
      input  mem_read_valid,
      input  mem_read_address,
      output mem_read_ready,
      output mem_read_data
   );
endinterface

// File: rtl/cached_fetcher_icache_array.sv
// Direct-mapped instruction cache storage: valid bits (reset and clear-all),
// tags and data (no reset), one combinational lookup port and one write port.
// A clear-all on the same edge as a write wins, leaving the line invalid.
module icache_array
   import cached_fetcher_pkg::*;
#(
   parameter int LINES      = 8,
   parameter int INDEX_BITS = 3,
   parameter int TAG_BITS   = 5,
   parameter int DATA_BITS  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [INDEX_BITS-1:0] i_rd_index,
   output logic                  o_rd_valid,
   output logic [TAG_BITS-1:0]   o_rd_tag,
   output logic [DATA_BITS-1:0]  o_rd_data,
   input  logic                  i_wr_en,
   input  logic [INDEX_BITS-1:0] i_wr_index,
   input  logic [TAG_BITS-1:0]   i_wr_tag,
   input  logic [DATA_BITS-1:0]  i_wr_data,
   input  logic                  i_clear_all
);

   logic [LINES-1:0]     r_valid;
   logic [TAG_BITS-1:0]  r_tag  [LINES];
   logic [DATA_BITS-1:0] r_data [LINES];

   // Valid bits: cleared by reset or clear-all, set by a fill.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
      end else if (i_clear_all) begin
         r_valid <= '0;
      end else if (i_wr_en) begin
         r_valid[i_wr_index] <= 1'b1;
      end
   end

   // Tag and data payload; contents are meaningless until the valid bit is set.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_tag[i_wr_index]  <= i_wr_tag;
         r_data[i_wr_index] <= i_wr_data;
      end
   end

   assign o_rd_valid = r_valid[i_rd_index];
   assign o_rd_tag   = r_tag[i_rd_index];
   assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/cached_fetcher.sv
// Instruction fetcher with a direct-mapped cache in front of program memory.
// Hits complete in one edge; misses issue one request and fill the line.
module cached_fetcher
   import cached_fetcher_pkg::*;
#(
   parameter int PROGRAM_MEM_ADDR_BITS = 8,
   parameter int PROGRAM_MEM_DATA_BITS = 16,
   parameter int CACHE_LINES           = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [2:0]                       core_state,
   input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
   input  logic                             invalidate,
   cached_fetcher_if.master                 mem,
   output logic [2:0]                       fetcher_state,
   output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
   output logic [COUNT_BITS-1:0]            hit_count,
   output logic [COUNT_BITS-1:0]            miss_count
);

   localparam int INDEX_BITS = $clog2(CACHE_LINES);
   localparam int TAG_BITS   = PROGRAM_MEM_ADDR_BITS - INDEX_BITS;

   fetcher_state_t                    r_state;
   fetcher_state_t                    w_state_next;
   logic [PROGRAM_MEM_ADDR_BITS-1:0]  r_addr;
   logic [PROGRAM_MEM_DATA_BITS-1:0]  r_instr;
   logic [COUNT_BITS-1:0]             r_hit;
   logic [COUNT_BITS-1:0]             r_miss;

   logic                              w_rd_valid;
   logic [TAG_BITS-1:0]               w_rd_tag;
   logic [PROGRAM_MEM_DATA_BITS-1:0]  w_rd_data;
   logic [INDEX_BITS-1:0]             w_lookup_index;
   logic [TAG_BITS-1:0]               w_lookup_tag;
   logic                              w_hit;
   logic                              w_count_hit;
   logic                              w_count_miss;
   logic                              w_fill;

   assign w_lookup_index = current_pc[INDEX_BITS-1:0];
   assign w_lookup_tag   = current_pc[PROGRAM_MEM_ADDR_BITS-1:INDEX_BITS];
   assign w_hit          = w_rd_valid && (w_rd_tag == w_lookup_tag);

   // The fill targets the line of the latched request address, not the live pc.
   icache_array #(
      .LINES      (CACHE_LINES),
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS),
      .DATA_BITS  (PROGRAM_MEM_DATA_BITS)
   ) u_array (
      .clk         (clk),
      .reset       (reset),
      .i_rd_index  (w_lookup_index),
      .o_rd_valid  (w_rd_valid),
      .o_rd_tag    (w_rd_tag),
      .o_rd_data   (w_rd_data),
      .i_wr_en     (w_fill),
      .i_wr_index  (r_addr[INDEX_BITS-1:0]),
      .i_wr_tag    (r_addr[PROGRAM_MEM_ADDR_BITS-1:INDEX_BITS]),
      .i_wr_data   (mem.mem_read_data),
      .i_clear_all (invalidate)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= FETCHER_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and per-edge actions; memory response only matters while FETCHING.
   always_comb begin
      w_state_next = r_state;
      w_count_hit  = 1'b0;
      w_count_miss = 1'b0;
      w_fill       = 1'b0;
      case (r_state)
         FETCHER_IDLE: begin
            if (core_state == CORE_FETCH) begin
               if (w_hit) begin
                  w_count_hit  = 1'b1;
                  w_state_next = FETCHER_FETCHED;
               end else begin
                  w_count_miss = 1'b1;
                  w_state_next = FETCHER_FETCHING;
               end
            end
         end
         FETCHER_FETCHING: begin
            if (mem.mem_read_ready) begin
               w_fill       = 1'b1;
               w_state_next = FETCHER_FETCHED;
            end
         end
         FETCHER_FETCHED: begin
            if (core_state == CORE_DECODE) begin
               w_state_next = FETCHER_IDLE;
            end
         end
         default: begin
            w_state_next = FETCHER_IDLE;
         end
      endcase
   end

   // Request address, delivered instruction and saturating statistics.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr  <= '0;
         r_instr <= '0;
         r_hit   <= '0;
         r_miss  <= '0;
      end else begin
         if (w_count_miss) begin
            r_addr <= current_pc;
            r_miss <= sat_inc(r_miss);
         end
         if (w_count_hit) begin
            r_instr <= w_rd_data;
            r_hit   <= sat_inc(r_hit);
         end
         if (w_fill) begin
            r_instr <= mem.mem_read_data;
         end
      end
   end

   assign mem.mem_read_valid   = (r_state == FETCHER_FETCHING);
   assign mem.mem_read_address = r_addr;
   assign fetcher_state        = r_state;
   assign instruction          = r_instr;
   assign hit_count            = r_hit;
   assign miss_count           = r_miss;

endmodule

// File: tb/tb_cached_fetcher.sv
// Directed bench for cached_fetcher: cold miss, hit, conflict, invalidate,
// invalidate on the fill edge and reset during an outstanding request.
module tb_cached_fetcher;

   logic        clk;
   logic        reset;
   logic [2:0]  core_state;
   logic [7:0]  current_pc;
   logic        invalidate;
   logic [2:0]  fetcher_state;
   logic [15:0] instruction;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   int n_checks;
   int n_fails;

   cached_fetcher_if #(.ADDR_BITS(8), .DATA_BITS(16)) mem_bus ();

   cached_fetcher #(
      .PROGRAM_MEM_ADDR_BITS (8),
      .PROGRAM_MEM_DATA_BITS (16),
      .CACHE_LINES           (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .core_state    (core_state),
      .current_pc    (current_pc),
      .invalidate    (invalidate),
      .mem           (mem_bus),
      .fetcher_state (fetcher_state),
      .instruction   (instruction),
      .hit_count     (hit_count),
      .miss_count    (miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a FETCH for pc for one edge, then let the scheduler wait.
   task automatic start_lookup(input logic [7:0] pc);
      current_pc = pc;
      core_state = 3'b001;
      step();
      core_state = 3'b000;
   endtask

   // Memory answers on the next edge.
   task automatic respond(input logic [15:0] data);
      mem_bus.mem_read_ready = 1'b1;
      mem_bus.mem_read_data  = data;
      step();
      mem_bus.mem_read_ready = 1'b0;
   endtask

   // Scheduler moves to DECODE, fetcher returns to IDLE.
   task automatic release_fetch();
      core_state = 3'b010;
      step();
      core_state = 3'b000;
   endtask

   task automatic test_reset();
      #2;
      n_checks++; if (fetcher_state !== 3'b000) begin n_fails++; $display("FAIL rst_state: got %0h expected 0", fetcher_state); end
      n_checks++; if (mem_bus.mem_read_valid !== 1'b0) begin n_fails++; $display("FAIL rst_valid: got %0b expected 0", mem_bus.mem_read_valid); end
      n_checks++; if (mem_bus.mem_read_address !== 8'h00) begin n_fails++; $display("FAIL rst_addr: got %0h expected 0", mem_bus.mem_read_address); end
      n_checks++; if (instruction !== 16'h0000) begin n_fails++; $display("FAIL rst_instr: got %0h expected 0", instruction); end
      n_checks++; if (hit_count !== 16'd0) begin n_fails++; $display("FAIL rst_hit: got %0d expected 0", hit_count); end
      n_checks++; if (miss_count !== 16'd0) begin n_fails++; $display("FAIL rst_miss: got %0d expected 0", miss_count); end
      @(negedge clk);
      reset = 1'b1;
      step();
   endtask

   task automatic test_cold_miss();
      int vcnt;
      vcnt = 0;
      start_lookup(8'h05);
      n_checks++; if (fetcher_state !== 3'b001) begin n_fails++; $display("FAIL cold_state: got %0h expected 1", fetcher_state); end
      n_checks++; if (miss_count !== 16'd1) begin n_fails++; $display("FAIL cold_miss_cnt: got %0d expected 1", miss_count); end
      for (int i = 0; i < 3; i++) begin
         if (mem_bus.mem_read_valid === 1'b1) vcnt++;
         n_checks++; if (mem_bus.mem_read_address !== 8'h05) begin n_fails++; $display("FAIL cold_addr: got %0h expected 05", mem_bus.mem_read_address); end
         if (i == 2) begin
            respond(16'h1234);
         end else begin
            step();
         end
      end
      n_checks++; if (vcnt !== 3) begin n_fails++; $display("FAIL cold_valid_cycles: got %0d expected 3", vcnt); end
      n_checks++; if (mem_bus.mem_read_valid !== 1'b0) begin n_fails++; $display("FAIL cold_valid_drop: got %0b expected 0", mem_bus.mem_read_valid); end
      n_checks++; if (fetcher_state !== 3'b010) begin n_fails++; $display("FAIL cold_fetched: got %0h expected 2", fetcher_state); end
      n_checks++; if (instruction !== 16'h1234) begin n_fails++; $display("FAIL cold_instr: got %0h expected 1234", instruction); end
      // Stray response while FETCHED and no DECODE: nothing moves.
      respond(16'hFFFF);
      n_checks++; if (fetcher_state !== 3'b010) begin n_fails++; $display("FAIL hold_state: got %0h expected 2", fetcher_state); end
      n_checks++; if (instruction !== 16'h1234) begin n_fails++; $display("FAIL hold_instr: got %0h expected 1234", instruction); end
      release_fetch();
      n_checks++; if (fetcher_state !== 3'b000) begin n_fails++; $display("FAIL decode_idle: got %0h expected 0", fetcher_state); end
      // IDLE without FETCH stays idle and requests nothing.
      step();
      n_checks++; if (fetcher_state !== 3'b000 || mem_bus.mem_read_valid !== 1'b0) begin n_fails++; $display("FAIL idle_stay: got state %0h valid %0b expected 0 0", fetcher_state, mem_bus.mem_read_valid); end
   endtask

   task automatic test_hit();
      start_lookup(8'h05);
      n_checks++; if (fetcher_state !== 3'b010) begin n_fails++; $display("FAIL hit_state: got %0h expected 2", fetcher_state); end
      n_checks++; if (mem_bus.mem_read_valid !== 1'b0) begin n_fails++; $display("FAIL hit_no_req: got %0b expected 0", mem_bus.mem_read_valid); end
      n_checks++; if (instruction !== 16'h1234) begin n_fails++; $display("FAIL hit_instr: got %0h expected 1234", instruction); end
      n_checks++; if (hit_count !== 16'd1) begin n_fails++; $display("FAIL hit_cnt: got %0d expected 1", hit_count); end
      n_checks++; if (miss_count !== 16'd1) begin n_fails++; $display("FAIL hit_miss_cnt: got %0d expected 1", miss_count); end
      release_fetch();
   endtask

   task automatic test_conflict();
      start_lookup(8'h0D);
      n_checks++; if (fetcher_state !== 3'b001) begin n_fails++; $display("FAIL conf_0d_state: got %0h expected 1", fetcher_state); end
      n_checks++; if (mem_bus.mem_read_address !== 8'h0D) begin n_fails++; $display("FAIL conf_0d_addr: got %0h expected 0d", mem_bus.mem_read_address); end
      n_checks++; if (miss_count !== 16'd2) begin n_fails++; $display("FAIL conf_0d_miss: got %0d expected 2", miss_count); end
      current_pc = 8'h77;
      step();
      n_checks++; if (mem_bus.mem_read_address !== 8'h0D) begin n_fails++; $display("FAIL conf_pc_change: got %0h expected 0d", mem_bus.mem_read_address); end
      respond(16'hBEEF);
      n_checks++; if (instruction !== 16'hBEEF) begin n_fails++; $display("FAIL conf_0d_instr: got %0h expected beef", instruction); end
      release_fetch();
      start_lookup(8'h05);
      n_checks++; if (fetcher_state !== 3'b001) begin n_fails++; $display("FAIL conf_05_state: got %0h expected 1", fetcher_state); end
      n_checks++; if (mem_bus.mem_read_address !== 8'h05) begin n_fails++; $display("FAIL conf_05_addr: got %0h expected 05", mem_bus.mem_read_address); end
      n_checks++; if (miss_count !== 16'd3) begin n_fails++; $display("FAIL conf_05_miss: got %0d expected 3", miss_count); end
      respond(16'h5555);
      release_fetch();
      start_lookup(8'h05);
      n_checks++; if (fetcher_state !== 3'b010 || instruction !== 16'h5555) begin n_fails++; $display("FAIL conf_rehit: got state %0h instr %0h expected 2 5555", fetcher_state, instruction); end
      n_checks++; if (hit_count !== 16'd2) begin n_fails++; $display("FAIL conf_hit_cnt: got %0d expected 2", hit_count); end
      release_fetch();
   endtask

   task automatic test_invalidate();
      invalidate = 1'b1;
      step();
      invalidate = 1'b0;
      start_lookup(8'h05);
      n_checks++; if (fetcher_state !== 3'b001) begin n_fails++; $display("FAIL inv_state: got %0h expected 1", fetcher_state); end
      n_checks++; if (miss_count !== 16'd4) begin n_fails++; $display("FAIL inv_miss: got %0d expected 4", miss_count); end
      // Invalidate while a request is outstanding must not cancel it.
      invalidate = 1'b1;
      step();
      invalidate = 1'b0;
      n_checks++; if (fetcher_state !== 3'b001 || mem_bus.mem_read_valid !== 1'b1) begin n_fails++; $display("FAIL inv_no_abort: got state %0h valid %0b expected 1 1", fetcher_state, mem_bus.mem_read_valid); end
      respond(16'h7777);
      n_checks++; if (instruction !== 16'h7777) begin n_fails++; $display("FAIL inv_instr: got %0h expected 7777", instruction); end
      release_fetch();
      start_lookup(8'h05);
      n_checks++; if (fetcher_state !== 3'b010 || hit_count !== 16'd3) begin n_fails++; $display("FAIL inv_refill_hit: got state %0h hits %0d expected 2 3", fetcher_state, hit_count); end
      release_fetch();
   endtask

   task automatic test_invalidate_on_fill();
      start_lookup(8'h22);
      n_checks++; if (miss_count !== 16'd5) begin n_fails++; $display("FAIL invf_miss: got %0d expected 5", miss_count); end
      invalidate = 1'b1;
      respond(16'hA5A5);
      invalidate = 1'b0;
      n_checks++; if (fetcher_state !== 3'b010) begin n_fails++; $display("FAIL invf_state: got %0h expected 2", fetcher_state); end
      n_checks++; if (instruction !== 16'hA5A5) begin n_fails++; $display("FAIL invf_instr: got %0h expected a5a5", instruction); end
      release_fetch();
      start_lookup(8'h22);
      n_checks++; if (fetcher_state !== 3'b001 || miss_count !== 16'd6) begin n_fails++; $display("FAIL invf_remiss: got state %0h misses %0d expected 1 6", fetcher_state, miss_count); end
      respond(16'h1111);
      release_fetch();
      start_lookup(8'h05);
      n_checks++; if (fetcher_state !== 3'b001 || miss_count !== 16'd7) begin n_fails++; $display("FAIL invf_other_line: got state %0h misses %0d expected 1 7", fetcher_state, miss_count); end
      respond(16'h7777);
      release_fetch();
   endtask

   task automatic test_reset_mid_fetch();
      start_lookup(8'h33);
      n_checks++; if (mem_bus.mem_read_valid !== 1'b1) begin n_fails++; $display("FAIL rmf_req: got %0b expected 1", mem_bus.mem_read_valid); end
      #2;
      reset = 1'b0;
      #1;
      n_checks++; if (mem_bus.mem_read_valid !== 1'b0) begin n_fails++; $display("FAIL rmf_valid: got %0b expected 0", mem_bus.mem_read_valid); end
      n_checks++; if (fetcher_state !== 3'b000) begin n_fails++; $display("FAIL rmf_state: got %0h expected 0", fetcher_state); end
      n_checks++; if (mem_bus.mem_read_address !== 8'h00) begin n_fails++; $display("FAIL rmf_addr: got %0h expected 0", mem_bus.mem_read_address); end
      n_checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin n_fails++; $display("FAIL rmf_counts: got %0d %0d expected 0 0", hit_count, miss_count); end
      n_checks++; if (instruction !== 16'h0000) begin n_fails++; $display("FAIL rmf_instr: got %0h expected 0", instruction); end
      #2;
      reset = 1'b1;
      step();
      respond(16'hDEAD);
      n_checks++; if (fetcher_state !== 3'b000 || instruction !== 16'h0000 || mem_bus.mem_read_valid !== 1'b0) begin n_fails++; $display("FAIL rmf_late_ready: got state %0h instr %0h valid %0b expected 0 0 0", fetcher_state, instruction, mem_bus.mem_read_valid); end
      start_lookup(8'h05);
      n_checks++; if (fetcher_state !== 3'b001 || miss_count !== 16'd1 || hit_count !== 16'd0) begin n_fails++; $display("FAIL rmf_cold_after: got state %0h misses %0d hits %0d expected 1 1 0", fetcher_state, miss_count, hit_count); end
      respond(16'h4321);
      release_fetch();
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      reset = 1'b0;
      core_state = 3'b000;
      current_pc = 8'h00;
      invalidate = 1'b0;
      mem_bus.mem_read_ready = 1'b0;
      mem_bus.mem_read_data  = 16'h0000;
      test_reset();
      test_cold_miss();
      test_hit();
      test_conflict();
      test_invalidate();
      test_invalidate_on_fill();
      test_reset_mid_fetch();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
